// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, 256-byte little-endian instruction memory and
// the IF/OF pipeline register, with stall hold, branch redirect and HALT stop.
module fetch_stage #(
  parameter logic [7:0]  START_PC    = 8'h00,
  parameter logic [3:0]  HALT_OPCODE = 4'hF,
  parameter logic [23:0] NOP_WORD    = 24'h000800
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_en,
  input  logic [7:0]  load_addr,
  input  logic [7:0]  load_data,
  input  logic        start,
  input  logic        data_stall,
  input  logic [8:0]  Branch_Update_with_isBranch,
  output logic [23:0] IF_output,
  output logic        if_valid,
  output logic [7:0]  pc,
  output logic [1:0]  state,
  output logic [15:0] fetch_count
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_HALT = 2'b10;
  localparam logic [7:0] PC_INIT = {START_PC[7:1], 1'b0};

  logic [7:0]  mem [256];
  logic [1:0]  state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [23:0] if_out_q, if_out_d;
  logic        if_valid_q, if_valid_d;
  logic [15:0] fetch_cnt_q, fetch_cnt_d;

  logic [15:0] instr;
  logic        br_taken;
  logic [7:0]  br_target;

  // The high byte address wraps naturally through the 8-bit add.
  assign instr     = {mem[pc_q + 8'd1], mem[pc_q]};
  assign br_taken  = Branch_Update_with_isBranch[8];
  assign br_target = {Branch_Update_with_isBranch[7:1], 1'b0};

  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && load_en) begin
      mem[load_addr] <= load_data;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    if_out_d    = if_out_q;
    if_valid_d  = if_valid_q;
    fetch_cnt_d = fetch_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if_out_d   = NOP_WORD;
        if_valid_d = 1'b0;
        if (start) begin
          state_d = ST_RUN;
          pc_d    = PC_INIT;
        end
      end
      ST_RUN, ST_HALT: begin
        // Redirect outranks stall; a stall freezes everything else.
        if (br_taken) begin
          state_d    = ST_RUN;
          pc_d       = br_target;
          if_out_d   = NOP_WORD;
          if_valid_d = 1'b0;
        end else if (data_stall) begin
          state_d = state_q;
        end else if (state_q == ST_RUN) begin
          if_out_d    = {instr, pc_q};
          if_valid_d  = 1'b1;
          pc_d        = pc_q + 8'd2;
          fetch_cnt_d = fetch_cnt_q + 16'd1;
          if (instr[3:0] == HALT_OPCODE) begin
            state_d = ST_HALT;
          end
        end else begin
          if_out_d   = NOP_WORD;
          if_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pc_q        <= PC_INIT;
      if_out_q    <= NOP_WORD;
      if_valid_q  <= 1'b0;
      fetch_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      if_out_q    <= if_out_d;
      if_valid_q  <= if_valid_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign IF_output   = if_out_q;
  assign if_valid    = if_valid_q;
  assign pc          = pc_q;
  assign state       = state_q;
  assign fetch_count = fetch_cnt_q;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage pipeline. It holds the program counter, an internal 256-byte instruction memory loaded before execution, and the IF/OF pipeline register that feeds operand fetch. It honours data-stall hold requests from the stalling unit and branch redirects from the EX/MA boundary, inserting one NOP bubble per redirect. It stops fetching on a HALT opcode.

## Interface
Parameters:
- START_PC, 8'h00, PC loaded at reset and on start; bit 0 forced to 0.
- HALT_OPCODE, 4'hF, opcode value (instruction bits [3:0]) that stops fetching.
- NOP_WORD, 24'h000800, IF/OF bubble value: opcode 4'b1000, all other fields 0.

Ports:
- clk  in  1  Pipeline clock. All state changes on posedge.
- reset  in  1  Synchronous, active-high.
- load_en  in  1  Instruction-memory byte write strobe; honoured only in IDLE.
- load_addr  in  8  Byte address for the load write.
- load_data  in  8  Byte written.
- start  in  1  One-cycle pulse, IDLE → RUN.
- data_stall  in  1  Hold PC and IF_output this cycle.
- Branch_Update_with_isBranch  in  9  Bit [8] is taken; bits [7:0] are the target PC.
- IF_output  out  24  IF/OF register: {instr[15:0], pc[7:0]}; opcode is at [11:8].
- if_valid  out  1  IF_output holds a real instruction rather than a bubble.
- pc  out  8  Current program counter.
- state  out  2  00 IDLE, 01 RUN, 10 HALT.
- fetch_count  out  16  Number of valid instructions latched; wraps at 16'hFFFF → 0.

## Operation
- Memory: 256 × 8 bits, little-endian. instr = {mem[pc+1], mem[pc]}, with the address computed mod 256, so pc = 8'hFF reads mem[0] as the high byte. Read is combinational from pc.
- Memory contents are not cleared by reset.
- IDLE:
  - load_en writes mem[load_addr] <= load_data.
  - IF_output = NOP_WORD, if_valid = 0.
  - start → RUN with pc = START_PC.
  - data_stall and branch inputs are ignored.
- RUN, per cycle. Priority is redirect > stall > normal.
  - Redirect (taken = 1): pc <= {target[7:1], 1'b0}; IF_output <= NOP_WORD; if_valid <= 0. Any stall is overridden that cycle.
  - Stall: pc, IF_output, if_valid and fetch_count all hold.
  - Normal: IF_output <= {instr, pc}; if_valid <= 1; pc <= pc + 2 (mod 256); fetch_count increments.
  - If the latched instr[3:0] == HALT_OPCODE, the HALT instruction itself is latched as valid and the state moves to HALT. pc still advances by 2.
- HALT:
  - Stall holds everything, so the latched HALT instruction stays in place while OF is stalled.
  - Otherwise IF_output <= NOP_WORD, if_valid <= 0, and pc holds.
  - A redirect (an older branch still in flight) → RUN at the target with one bubble.
- load_en outside IDLE is ignored (memory unchanged). start outside IDLE is ignored.
- Reset values: state IDLE, pc = START_PC, IF_output = NOP_WORD, if_valid = 0, fetch_count = 0. Reset mid-RUN or mid-HALT discards all in-flight state on that edge; memory contents are retained.

## Timing
- Fetch latency is 1 cycle: pc = P at edge n gives IF_output = {instr(P), P} after edge n.
- Redirect penalty is 1 bubble. A taken branch sampled at edge n produces NOP_WORD after edge n and the target instruction after edge n+1.
- A stall asserted for k cycles holds IF_output for exactly k edges; fetching resumes on the first edge where data_stall = 0.
- The start pulse at edge n gives state RUN after edge n and the first valid instruction after edge n+1.
- If a redirect and a HALT fetch happen on the same edge, the redirect wins: the HALT is not latched, state stays RUN, and fetch_count does not increment.
- PC wraps 8'hFE + 2 → 8'h00 with no error.

## Test plan
- Load and run: load mem[0..5] = 12,34,56,78,9A,BC, pulse start → IF_output = 24'h341200, 24'h785602, 24'hBC9A04 on consecutive cycles; fetch_count = 3.
- Stall: assert data_stall for 2 cycles while IF_output = 24'h785602 → value held for 2 edges, pc holds at 04, then 24'hBC9A04 follows.
- Redirect under stall: data_stall = 1 and Branch_Update_with_isBranch = 9'h1_21 on the same edge → IF_output = 24'h000800, pc = 20, next edge fetches the instruction at address 20.
- HALT: mem[6] = 8'h0F → instruction latched with if_valid = 1, state = HALT, NOPs with if_valid = 0 thereafter, pc frozen at 08; a later redirect to 00 → state RUN.
- Wrap: START_PC = FE, mem[FF] = AA, mem[FE] = 55, mem[0] = 11 → IF_output = 24'hAA55FE, then pc = 00.
- Reset in RUN: pulse reset → state IDLE, IF_output = 24'h000800, fetch_count = 0, memory intact; a load_en during RUN leaves memory unchanged.
